// File: rtl/sram_decrypt_pkg.sv
// Shared types and constants for the decrypting SRAM reader.
package sram_decrypt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
    localparam int unsigned FIFO_DEPTH    = 2;
    localparam logic [7:0]  LFSR_ZERO_SUB = 8'h01;

    // One keystream step: shift left, feedback from bits 7,5,4,3.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// 8-bit keystream LFSR.
//   clk, rst_n : clock, async active-low reset (key resets to 8'h01)
//   load, seed : load seed (zero seed replaced by 8'h01)
//   step       : advance one step
//   key        : current keystream byte
module keystream_lfsr
    import sram_decrypt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] key
);

    logic [7:0] r_key;

    // A zero state would lock the LFSR, so it is never loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= LFSR_ZERO_SUB;
        end else if (load) begin
            r_key <= (seed == 8'h00) ? LFSR_ZERO_SUB : seed;
        end else if (step) begin
            r_key <= lfsr_next(r_key);
        end
    end

    assign key = r_key;

endmodule

// File: rtl/sram_decrypt_reader.sv
// Sweeps an SRAM address range, XOR-decrypts each word with an LFSR
// keystream and streams plaintext out on valid/ready.
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_start/i_base/i_len/i_key : job command (sampled in IDLE)
//   o_sram_addr, o_sram_write, i_sram_data : SRAM read port (1-cycle latency)
//   o_data, o_valid, i_ready : plaintext output stream
//   o_busy, o_done         : job status
module sram_decrypt_reader
    import sram_decrypt_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH-1:0] i_len,
    input  logic [7:0]            i_key,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_sram_write,
    input  logic [DATA_WIDTH-1:0] i_sram_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned KEY_REPS = DATA_WIDTH / 8;
    localparam int unsigned ADDR_MAX = DEPTH - 1;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_len, r_issued, r_addr, w_addr_inc;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
    logic [1:0]            r_count;
    logic                  r_done, r_busy;
    logic                  w_pop, w_push, w_issue, w_load, w_done_next;
    logic [2:0]            w_occ;
    logic [7:0]            w_key;

    assign w_pop  = (r_count != 2'd0) && i_ready;
    assign w_push = r_inflight;
    // Occupancy counts the slot freed by this cycle's pop so reads stream back to back.
    assign w_occ  = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_addr_inc = (r_addr == ADDR_WIDTH'(ADDR_MAX)) ? '0 : r_addr + ADDR_WIDTH'(1);

    // Next-state and control decode.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_load       = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        w_load       = 1'b1;
                        w_state_next = READ;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            READ: begin
                if (w_occ < 3'(FIFO_DEPTH)) begin
                    w_issue = 1'b1;
                    if (r_issued + ADDR_WIDTH'(1) == r_len) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last word leaves when nothing else is stored or arriving.
                if (w_pop && (r_count == 2'd1) && !r_inflight) begin
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, counters, status and output buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_count    <= 2'd0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_done     <= w_done_next;
            r_inflight <= w_issue;
            // Busy spans through the o_done cycle, dropping the cycle after.
            if (w_load) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
            if (w_load) begin
                r_len    <= i_len;
                r_issued <= '0;
                r_addr   <= i_base;
            end else if (w_issue) begin
                r_issued <= r_issued + ADDR_WIDTH'(1);
                r_addr   <= w_addr_inc;
            end
            // Head of the buffer always sits in r_buf0.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_buf0 <= i_sram_data;
                    else                 r_buf1 <= i_sram_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf0  <= r_buf1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= i_sram_data;
                    end else begin
                        r_buf0 <= i_sram_data;
                    end
                end
                default: ;
            endcase
        end
    end

    keystream_lfsr u_lfsr (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .load  (w_load),
        .seed  (i_key),
        .step  (w_pop),
        .key   (w_key)
    );

    assign o_sram_addr  = r_addr;
    assign o_sram_write = 1'b0;
    assign o_valid      = (r_count != 2'd0);
    assign o_data       = o_valid ? (r_buf0 ^ {KEY_REPS{w_key}}) : '0;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_sram_decrypt_reader.sv
// Directed bench for sram_decrypt_reader with a 1-cycle-latency SRAM model.
module tb_sram_decrypt_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_base = '0, i_len = '0, i_key = '0;
    logic [7:0] o_sram_addr;
    logic       o_sram_write;
    logic [7:0] sram_q = '0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic       o_busy, o_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:255];
    logic [7:0] got [0:15];
    logic [7:0] exp_v [0:7];
    int         n_got, first_valid_cyc, done_cyc;
    logic       busy_at_done, busy_after_done, saw_busy, stable_ok;
    logic [7:0] addr_c1;

    sram_decrypt_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_base       (i_base),
        .i_len        (i_len),
        .i_key        (i_key),
        .o_sram_addr  (o_sram_addr),
        .o_sram_write (o_sram_write),
        .i_sram_data  (sram_q),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sram_q <= mem[o_sram_addr];

    // Drives one job and records what comes out; inputs change and outputs
    // are sampled at the falling edge.
    task automatic run_job(input logic [7:0] base, input logic [7:0] len, input logic [7:0] key,
                           input bit bp, input int restart_cyc, input int max_cyc);
        logic [5:0] pat;
        bit         prev_stall;
        logic [7:0] prev_data;
        pat = 6'b101001;
        for (int k = 0; k < 16; k++) got[k] = 'x;
        n_got = 0; first_valid_cyc = -1; done_cyc = -1;
        stable_ok = 1'b1; saw_busy = 1'b0; busy_at_done = 1'b0; addr_c1 = 'x;
        prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        i_base = base; i_len = len; i_key = key; i_start = 1'b1; i_ready = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            i_start = (c == restart_cyc);
            if (c == restart_cyc) begin
                i_base = 8'h80; i_key = 8'h3C; i_len = 8'h02;
            end
            i_ready = bp ? pat[(c - 1) % 6] : 1'b1;
            if (c == 1) addr_c1 = o_sram_addr;
            if (o_busy === 1'b1) saw_busy = 1'b1;
            if (o_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = c;
            if (prev_stall && (o_valid !== 1'b1 || o_data !== prev_data)) stable_ok = 1'b0;
            if (o_valid === 1'b1 && i_ready && n_got < 16) begin
                got[n_got] = o_data;
                n_got++;
            end
            prev_stall = (o_valid === 1'b1) && !i_ready;
            prev_data  = o_data;
            if (o_done === 1'b1) begin
                done_cyc     = c;
                busy_at_done = o_busy;
                break;
            end
        end
        @(negedge clk);
        i_start = 1'b0;
        busy_after_done = o_busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags got v=%b b=%b d=%b want 0 0 0", o_valid, o_busy, o_done);
        end
        n_checks++;
        if (o_sram_addr !== 8'h00 || o_data !== 8'h00 || o_sram_write !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_bus got addr=%h data=%h wr=%b want 00 00 0", o_sram_addr, o_data, o_sram_write);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        exp_v[0] = 8'hB4; exp_v[1] = 8'h68; exp_v[2] = 8'hA6; exp_v[3] = 8'h6E;
        run_job(8'h00, 8'd4, 8'hA5, 1'b0, 0, 30);
        n_checks++;
        if (n_got != 4) begin
            n_errors++;
            $display("FAIL basic_count got %0d want 4", n_got);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got[k] !== exp_v[k]) begin
                n_errors++;
                $display("FAIL basic_word%0d got %h want %h", k, got[k], exp_v[k]);
            end
        end
        n_checks++;
        if (first_valid_cyc != 3) begin
            n_errors++;
            $display("FAIL basic_latency got %0d want 3", first_valid_cyc);
        end
        n_checks++;
        if (done_cyc != 7) begin
            n_errors++;
            $display("FAIL basic_done_cycle got %0d want 7", done_cyc);
        end
    endtask

    task automatic test_wrap();
        exp_v[0] = 8'h01; exp_v[1] = 8'hEF; exp_v[2] = 8'h84; exp_v[3] = 8'h08;
        run_job(8'hFE, 8'd4, 8'hA5, 1'b0, 0, 30);
        n_checks++;
        if (addr_c1 !== 8'hFE) begin
            n_errors++;
            $display("FAIL wrap_first_addr got %h want fe", addr_c1);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got[k] !== exp_v[k]) begin
                n_errors++;
                $display("FAIL wrap_word%0d got %h want %h", k, got[k], exp_v[k]);
            end
        end
        n_checks++;
        if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_busy got at_done=%b after=%b want 1 0", busy_at_done, busy_after_done);
        end
    endtask

    task automatic test_backpressure();
        exp_v[0] = 8'hEF; exp_v[1] = 8'h01; exp_v[2] = 8'hDD; exp_v[3] = 8'h63;
        exp_v[4] = 8'h1A; exp_v[5] = 8'hE6; exp_v[6] = 8'h1F; exp_v[7] = 8'hEA;
        run_job(8'h10, 8'd8, 8'hA5, 1'b1, 0, 60);
        n_checks++;
        if (n_got != 8 || done_cyc < 0) begin
            n_errors++;
            $display("FAIL bp_count got %0d words done_cyc=%0d want 8 words and done", n_got, done_cyc);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got[k] !== exp_v[k]) begin
                n_errors++;
                $display("FAIL bp_word%0d got %h want %h", k, got[k], exp_v[k]);
            end
        end
        n_checks++;
        if (stable_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_stall_stable got %b want 1", stable_ok);
        end
    endtask

    task automatic test_degenerate();
        run_job(8'h00, 8'd2, 8'h00, 1'b0, 0, 30);
        n_checks++;
        if (n_got != 2 || got[0] !== 8'h10 || got[1] !== 8'h20) begin
            n_errors++;
            $display("FAIL zero_key got n=%0d %h %h want 2 10 20", n_got, got[0], got[1]);
        end
        run_job(8'h00, 8'd0, 8'hA5, 1'b0, 0, 10);
        n_checks++;
        if (done_cyc != 1) begin
            n_errors++;
            $display("FAIL len0_done got cycle %0d want 1", done_cyc);
        end
        n_checks++;
        if (first_valid_cyc != -1 || saw_busy !== 1'b0 || busy_after_done !== 1'b0) begin
            n_errors++;
            $display("FAIL len0_quiet got valid_cyc=%0d busy=%b want -1 0", first_valid_cyc, saw_busy);
        end
    endtask

    task automatic test_start_while_busy();
        exp_v[0] = 8'hB4; exp_v[1] = 8'h68; exp_v[2] = 8'hA6;
        exp_v[3] = 8'h6E; exp_v[4] = 8'h0A; exp_v[5] = 8'hF6;
        run_job(8'h00, 8'd6, 8'hA5, 1'b0, 3, 40);
        n_checks++;
        if (n_got != 6 || done_cyc != 9) begin
            n_errors++;
            $display("FAIL busy_start_count got n=%0d done=%0d want 6 9", n_got, done_cyc);
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (got[k] !== exp_v[k]) begin
                n_errors++;
                $display("FAIL busy_start_word%0d got %h want %h", k, got[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        i_base = 8'h00; i_len = 8'd8; i_key = 8'hA5; i_start = 1'b1; i_ready = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_pre got v=%b b=%b want 1 1", o_valid, o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_data !== 8'h00) begin
            n_errors++;
            $display("FAIL rst_mid_async got v=%b b=%b d=%b data=%h want 0 0 0 00",
                     o_valid, o_busy, o_done, o_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_ready = 1'b1;
        exp_v[0] = 8'hB4; exp_v[1] = 8'h68; exp_v[2] = 8'hA6; exp_v[3] = 8'h6E;
        run_job(8'h00, 8'd4, 8'hA5, 1'b0, 0, 30);
        n_checks++;
        if (n_got != 4 || done_cyc != 7) begin
            n_errors++;
            $display("FAIL rst_mid_rerun got n=%0d done=%0d want 4 7", n_got, done_cyc);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got[k] !== exp_v[k]) begin
                n_errors++;
                $display("FAIL rst_mid_word%0d got %h want %h", k, got[k], exp_v[k]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_degenerate();
        test_start_while_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_decrypt_reader.md
# sram_decrypt_reader

Read-side companion to the encrypting SRAM. On a start command it sweeps a contiguous address range of the encrypted memory and XOR-decrypts each word with an LFSR keystream seeded from a key. It delivers plaintext words on a valid/ready stream toward the VGA pixel path, and a 2-entry output buffer absorbs the SRAM's 1-cycle read latency under backpressure.

## Interface
Parameters:
- ADDR_WIDTH, 8, SRAM address width
- DATA_WIDTH, 8, word width; must be a multiple of 8
- DEPTH, 256, SRAM depth; equals 2**ADDR_WIDTH

Ports:
- i_clk  in  1  sole clock
- i_rst_n  in  1  reset; asynchronous assert, active-low
- i_start  in  1  start pulse; sampled only in IDLE
- i_base  in  ADDR_WIDTH  first address to read
- i_len  in  ADDR_WIDTH  word count; 0 means no transfer
- i_key  in  8  LFSR seed; 0 is replaced by 8'h01
- o_sram_addr  out  ADDR_WIDTH  SRAM address
- o_sram_write  out  1  SRAM write strobe; tied 0, so the SRAM performs a read every cycle
- i_sram_data  in  DATA_WIDTH  SRAM read data, valid the cycle after the address is presented
- o_data  out  DATA_WIDTH  decrypted word
- o_valid  out  1  o_data valid
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle pulse after the last word is accepted

## Operation
- **FSM states:** IDLE, READ, DRAIN.
- **IDLE:**
  - i_start=1 and i_len!=0: latch base, len and seed (seed forced to 01 if 0), then go to READ.
  - i_start=1 and i_len=0: pulse o_done next cycle and stay in IDLE.
- **READ:**
  - A read issues when buffer count + in-flight count < 2.
  - An issued read drives o_sram_addr = base + issued_count, taken mod 2**ADDR_WIDTH, so the address wraps.
  - The in-flight flag is set for one cycle.
  - The cycle after an issue, i_sram_data is written into the buffer.
  - Once issued_count reaches len, go to DRAIN.
- **DRAIN:**
  - Wait until the last word is accepted.
  - Then pulse o_done and return to IDLE.
- **Decryption:**
  - Each output word is o_data = stored_word ^ {DATA_WIDTH/8{lfsr}}.
  - The LFSR advances only on an accepted word (o_valid && i_ready).
  - The first word uses the seed itself.
- **LFSR:** lfsr_next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- **Buffer:** 2-entry FIFO holding the raw SRAM words.
  - o_valid = FIFO not empty.
  - A push and a pop in the same cycle leave the count unchanged.
- **o_busy:** high from the cycle after an accepted start until the cycle o_done pulses, inclusive.
- **i_start while busy:** ignored. Base, len and key are not re-latched.
- **Reset (asynchronous, mid-operation allowed):** forces IDLE and clears the FIFO, counters and in-flight flag. Outputs go to:
  - o_valid=0, o_busy=0, o_done=0
  - o_sram_addr=0, o_data=0
  - lfsr=8'h01

## Timing
- Start sampled at edge 0. First address is driven in cycle 1, SRAM data arrives in cycle 2, and o_valid rises in cycle 3. First-word latency is 3 cycles.
- With i_ready held at 1, throughput is 1 word/cycle. len words complete with o_done at cycle len+3.
- When i_ready drops, at most 2 words are buffered (1 stored + 1 in flight, or 2 stored). No word is lost or duplicated.
- o_data and o_valid are stable while o_valid && !i_ready.
- o_done is registered. It is high for exactly 1 cycle, the cycle after the final handshake.

## Structure
- Package sram_decrypt_pkg holds:
  - state enum {IDLE, READ, DRAIN}
  - LFSR tap mask 8'hB8 (bits 7,5,4,3)
  - FIFO_DEPTH=2
  - LFSR_ZERO_SUB=8'h01
- One sub-module, keystream_lfsr, with ports clk, rst_n, load, seed, step and key.
- The FIFO and FSM are inline in sram_decrypt_reader.

## Test plan
- **Basic read:** memory [0..3] = 11,22,33,44; key=A5, base=0, len=4, i_ready=1.
  - Outputs are 11^A5=B4, then 22^4A=68, and so on per the LFSR sequence.
  - o_valid first asserts at cycle 3 and o_done pulses at cycle 7.
- **Wrap:** base=FE, len=4.
  - Addresses FE, FF, 00, 01 are read in order.
  - o_busy drops the cycle after o_done.
- **Backpressure:** i_ready toggles 1,0,0,1,0,1… during len=8.
  - All 8 words are delivered exactly once, in order, and correctly decrypted.
  - o_data is stable while stalled, and there are never more than 2 outstanding reads.
- **Degenerate inputs:** key=00 with len=2 decrypts using seed 01. A separate len=0 run gives an o_done pulse with no o_valid and o_busy staying 0.
- **Start while busy:** a second i_start with different base and key mid-transfer is ignored, and the output matches the original job.
- **Reset mid-operation:** i_rst_n is asserted asynchronously mid-transfer with o_valid=1.
  - o_valid, o_busy and o_done go to 0 immediately.
  - A fresh start afterwards reproduces the full expected sequence.
